p_layer_pipe: RTL and testbench

//  Elastic, multi-lane CS-Cipher P-layer. Each accepted word holds LANES bytes.

---
 rtl/p_layer_pipe_if.sv | 22 ++
 rtl/p_layer_pipe.sv | 103 ++++++++++
 tb/tb_p_layer_pipe.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/p_layer_pipe_if.sv
// Stream bundle for the P-layer: input word with lane mask, output substituted word.
interface p_layer_pipe_if #(
  parameter int LANES = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [8*LANES-1:0]   s_data;
  logic [LANES-1:0]     s_mask;
  logic                 m_valid;
  logic                 m_ready;
  logic [8*LANES-1:0]   m_data;

  modport master (
    output s_valid, s_data, s_mask, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_mask, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/p_layer_pipe.sv
// Masked CS-Cipher P substitution per byte lane, then a DEPTH-entry FIFO.
// 1-cycle latency into an empty FIFO; s_ready drops only when full.

module p_module (
  input  logic [7:0] x,
  output logic [7:0] y
);
  // Nibble boxes, entry n at bits [4n+3:4n]; P is a 3-round f/g/f Feistel.
  localparam logic [63:0] F_TAB = 64'hFEDE_BADE_7757_BBDF;
  localparam logic [63:0] G_TAB = 64'h97CF_354D_81EB_206A;

  function automatic logic [3:0] f_box(input logic [3:0] n);
    return F_TAB[{n, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] g_box(input logic [3:0] n);
    return G_TAB[{n, 2'b00} +: 4];
  endfunction

  logic [3:0] t_hi;
  logic [3:0] t_lo;

  always_comb begin
    t_hi = x[7:4] ^ f_box(x[3:0]);
    t_lo = x[3:0] ^ g_box(t_hi);
    y    = {t_hi ^ f_box(t_lo), t_lo};
  end
endmodule

module p_layer_pipe #(
  parameter int LANES = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  localparam int DW   = 8 * LANES,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  p_layer_pipe_if.slave    bus,
  output logic [LW-1:0]    level,
  output logic [CNT_W-1:0] word_cnt
);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [DW-1:0] lane_out;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] p_out;
    p_module u_p (
      .x (bus.s_data[8*i +: 8]),
      .y (p_out)
    );
    assign lane_out[8*i +: 8] = bus.s_mask[i] ? p_out : bus.s_data[8*i +: 8];
  end

  assign bus.s_ready = (level != FULL);
  assign bus.m_valid = (level != '0);
  assign bus.m_data  = bus.m_valid ? mem[rd_ptr] : '0;

  // Flush wins over any transfer in the same cycle.
  assign wr_en = bus.s_valid && bus.s_ready && !flush;
  assign rd_en = bus.m_valid && bus.m_ready && !flush;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= lane_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      word_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      word_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        level <= level + 1'b1;
      end else if (rd_en && !wr_en) begin
        level <= level - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_p_layer_pipe.sv
// Directed bench for p_layer_pipe: hand-computed P values, FIFO, flush and reset.
module tb_p_layer_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  level;
  logic [15:0] word_cnt;
  int          total = 0;
  int          passed = 0;

  logic [7:0]  p_head [16];
  logic [7:0]  out_tab [256];

  p_layer_pipe_if #(.LANES(8)) bus ();

  p_layer_pipe #(.LANES(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .level    (level),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    bus.s_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", bus.m_valid); else passed++;
    total++; if (bus.m_data !== 64'h0) $display("FAIL reset_m_data got %h want 0", bus.m_data); else passed++;
    total++; if (level !== 3'd0) $display("FAIL reset_level got %0d want 0", level); else passed++;
    total++; if (word_cnt !== 16'd0) $display("FAIL reset_word_cnt got %0d want 0", word_cnt); else passed++;
    total++; if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", bus.s_ready); else passed++;
    #20;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_mask();
    do_flush();
    bus.m_ready = 1'b0;
    bus.s_mask  = 8'hFF;
    bus.s_data  = 64'h0001_0203_2955_FF00;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    total++; if (bus.m_valid !== 1'b1) $display("FAIL v1_m_valid got %b want 1", bus.m_valid); else passed++;
    total++; if (bus.m_data !== 64'h290D_6140_00FF_5529) $display("FAIL v1_m_data got %h want 290d614000ff5529", bus.m_data); else passed++;
    total++; if (word_cnt !== 16'd1) $display("FAIL v1_word_cnt got %0d want 1", word_cnt); else passed++;
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    total++; if (level !== 3'd0) $display("FAIL v1_drain_level got %0d want 0", level); else passed++;
  endtask

  task automatic test_partial_mask();
    do_flush();
    bus.s_mask  = 8'h0F;
    bus.s_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    total++; if (bus.m_data !== 64'hFFFF_FFFF_5555_5555) $display("FAIL v2_m_data got %h want ffffffff55555555", bus.m_data); else passed++;
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_w;
    do_flush();
    bus.m_ready = 1'b0;
    bus.s_mask  = 8'h01;
    for (int k = 0; k < 5; k++) begin
      bus.s_data  = {56'hA5A5_A5A5_A5A5_A5, 8'(k)};
      bus.s_valid = 1'b1;
      tick();
    end
    bus.s_valid = 1'b0;
    total++; if (bus.s_ready !== 1'b0) $display("FAIL bp_s_ready got %b want 0", bus.s_ready); else passed++;
    total++; if (level !== 3'd4) $display("FAIL bp_level got %0d want 4", level); else passed++;
    total++; if (word_cnt !== 16'd4) $display("FAIL bp_word_cnt got %0d want 4", word_cnt); else passed++;
    total++; if (bus.m_data !== {56'hA5A5_A5A5_A5A5_A5, 8'h29}) $display("FAIL bp_hold got %h want a5a5a5a5a5a5a529", bus.m_data); else passed++;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_w = {56'hA5A5_A5A5_A5A5_A5, p_head[k]};
      total++; if (bus.m_data !== exp_w) $display("FAIL bp_order_%0d got %h want %h", k, bus.m_data, exp_w); else passed++;
      tick();
    end
    bus.m_ready = 1'b0;
    total++; if (level !== 3'd0 || bus.m_valid !== 1'b0) $display("FAIL bp_empty got level=%0d m_valid=%b want 0/0", level, bus.m_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int bubbles = 0;
    int bad_inv = 0;
    int first_bad = -1;
    logic [7:0] idx;
    logic [7:0] back;
    do_flush();
    bus.m_ready = 1'b1;
    bus.s_mask  = 8'h01;
    for (int i = 0; i < 256; i++) begin
      bus.s_data  = {56'h1234_5678_9ABC_DE, 8'(i)};
      bus.s_valid = 1'b1;
      tick();
      if (bus.m_valid !== 1'b1 || bus.s_ready !== 1'b1) bubbles++;
      out_tab[i] = bus.m_data[7:0];
      if (i == 100 && bus.m_data[63:8] !== 56'h1234_5678_9ABC_DE) bubbles++;
    end
    bus.s_valid = 1'b0;
    tick();
    total++; if (bubbles !== 0) $display("FAIL stream_bubbles got %0d want 0", bubbles); else passed++;
    total++; if (word_cnt !== 16'd256) $display("FAIL stream_word_cnt got %0d want 256", word_cnt); else passed++;
    total++; if (level !== 3'd0) $display("FAIL stream_level got %0d want 0", level); else passed++;
    for (int i = 0; i < 16; i++) begin
      total++; if (out_tab[i] !== p_head[i]) $display("FAIL stream_p_%0d got %h want %h", i, out_tab[i], p_head[i]); else passed++;
    end
    for (int i = 0; i < 256; i++) begin
      idx  = out_tab[i];
      back = out_tab[idx];
      if (back !== 8'(i)) begin
        bad_inv++;
        if (first_bad < 0) first_bad = i;
      end
    end
    total++; if (bad_inv !== 0) $display("FAIL stream_involution got %0d bad entries (first %0d) want 0", bad_inv, first_bad); else passed++;
    bus.m_ready = 1'b0;
  endtask

  task automatic test_loopback();
    logic [63:0] t;
    do_flush();
    bus.m_ready = 1'b0;
    bus.s_mask  = 8'hFF;
    bus.s_data  = 64'h0706_0504_0302_0100;
    bus.s_valid = 1'b1;
    tick();
    t = bus.m_data;
    total++; if (t !== 64'h8F9E_EB9C_4061_0D29) $display("FAIL loop_pass1 got %h want 8f9eeb9c40610d29", t); else passed++;
    bus.s_data  = t;
    bus.m_ready = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    total++; if (bus.m_data !== 64'h0706_0504_0302_0100) $display("FAIL loop_pass2 got %h want 0706050403020100", bus.m_data); else passed++;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic test_flush();
    do_flush();
    bus.m_ready = 1'b0;
    bus.s_mask  = 8'h00;
    for (int k = 0; k < 3; k++) begin
      bus.s_data  = 64'(k + 1);
      bus.s_valid = 1'b1;
      tick();
    end
    total++; if (level !== 3'd3) $display("FAIL flush_pre_level got %0d want 3", level); else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.s_valid = 1'b0;
    total++; if (level !== 3'd0) $display("FAIL flush_level got %0d want 0", level); else passed++;
    total++; if (word_cnt !== 16'd0) $display("FAIL flush_word_cnt got %0d want 0", word_cnt); else passed++;
    total++; if (bus.m_valid !== 1'b0 || bus.m_data !== 64'h0) $display("FAIL flush_m_out got %b/%h want 0/0", bus.m_valid, bus.m_data); else passed++;
  endtask

  task automatic test_reset_mid();
    do_flush();
    bus.m_ready = 1'b0;
    bus.s_mask  = 8'hFF;
    bus.s_data  = 64'hDEAD_BEEF_0BAD_F00D;
    bus.s_valid = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    bus.s_valid = 1'b0;
    total++; if (bus.m_valid !== 1'b0 || bus.m_data !== 64'h0) $display("FAIL rmid_m_out got %b/%h want 0/0", bus.m_valid, bus.m_data); else passed++;
    total++; if (level !== 3'd0 || word_cnt !== 16'd0) $display("FAIL rmid_state got level=%0d cnt=%0d want 0/0", level, word_cnt); else passed++;
    total++; if (bus.s_ready !== 1'b1) $display("FAIL rmid_s_ready got %b want 1", bus.s_ready); else passed++;
    #10;
    rst_n = 1'b1;
    tick();
    total++; if (bus.m_valid !== 1'b0) $display("FAIL rmid_after got m_valid=%b want 0", bus.m_valid); else passed++;
  endtask

  initial begin
    p_head = '{8'h29, 8'h0D, 8'h61, 8'h40, 8'h9C, 8'hEB, 8'h9E, 8'h8F,
               8'h1F, 8'h85, 8'h5F, 8'h58, 8'h5B, 8'h01, 8'h39, 8'h86};
    flush       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_mask  = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_full_mask();
    test_partial_mask();
    test_backpressure();
    test_back_to_back();
    test_loopback();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
